// File: rtl/common.sv
// Shared data-bus transaction types used by every master and slave in the core.
package common;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-side control types and helpers; holds the data-bus arbiter state.
package pipes;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Increment a port index, wrapping to zero at the port count.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purely combinational picker: first valid port at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  function automatic logic [IW-1:0] cand(input logic [IW-1:0] base, input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return IW'(sum);
  endfunction

  // Scan upward from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[cand(ptr, 32'(k))]) begin
        found = 1'b1;
        index = cand(ptr, 32'(k));
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Zero-latency data-bus arbiter: forwards one requester to the bus and holds the
// grant until data_ok or until the requester withdraws its valid.
module dbus_arbiter
  import common::*;
  import pipes::*;
#(
  parameter int NREQ = 2,
  parameter bit RR   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  dbus_req_t               ireq  [NREQ],
  output dbus_resp_t              iresp [NREQ],
  output dbus_req_t               oreq,
  input  dbus_resp_t              oresp,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gidx
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   lidx;
  logic [NREQ-1:0] vld;
  logic            found;
  logic [IW-1:0]   widx;
  logic [IW-1:0]   sel;
  logic            act;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] granted);
    if (!RR) return '0;
    return IW'(wrap_inc(32'(granted), NREQ));
  endfunction

  always_comb begin
    vld = '0;
    for (int i = 0; i < NREQ; i++) vld[i] = ireq[i].valid;
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid (vld),
    .ptr   (ptr),
    .found (found),
    .index (widx)
  );

  // While reset is held the bus is quiet even if requesters are already valid.
  always_comb begin
    sel  = '0;
    act  = 1'b0;
    gidx = '0;
    if (reset) begin
      if (state == LOCK) begin
        sel  = lidx;
        act  = ireq[lidx].valid;
        gidx = lidx;
      end else if (found) begin
        sel  = widx;
        act  = 1'b1;
        gidx = widx;
      end
    end
  end

  always_comb begin
    oreq = act ? ireq[sel] : '0;
    for (int i = 0; i < NREQ; i++) begin
      iresp[i] = (act && sel == IW'(i)) ? oresp : '0;
    end
  end

  assign busy = (state == LOCK);

  // A withdrawn valid in LOCK is an abort: it wins over data_ok and leaves ptr alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      lidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            if (oresp.data_ok) begin
              ptr <= next_ptr(widx);
            end else begin
              state <= LOCK;
              lidx  <= widx;
            end
          end
        end
        LOCK: begin
          if (!ireq[lidx].valid) begin
            state <= IDLE;
          end else if (oresp.data_ok) begin
            state <= IDLE;
            ptr   <= next_ptr(lidx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: three instances (2-port RR, 4-port RR, 4-port fixed)
// checked every cycle against a port-index reference model plus directed scenarios.
module tb_dbus_arbiter;
  import common::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  dbus_req_t  req0 [2];
  dbus_resp_t ir0  [2];
  dbus_req_t  oq0;
  dbus_resp_t rs0;
  logic       busy0;
  logic [0:0] g0;

  dbus_req_t  req1 [4];
  dbus_resp_t ir1  [4];
  dbus_req_t  oq1;
  dbus_resp_t rs1;
  logic       busy1;
  logic [1:0] g1;

  dbus_req_t  req2 [4];
  dbus_resp_t ir2  [4];
  dbus_req_t  oq2;
  dbus_resp_t rs2;
  logic       busy2;
  logic [1:0] g2;

  dbus_arbiter #(.NREQ(2), .RR(1'b1)) u0 (
    .clk(clk), .reset(reset), .ireq(req0), .iresp(ir0),
    .oreq(oq0), .oresp(rs0), .busy(busy0), .gidx(g0)
  );

  dbus_arbiter #(.NREQ(4), .RR(1'b1)) u1 (
    .clk(clk), .reset(reset), .ireq(req1), .iresp(ir1),
    .oreq(oq1), .oresp(rs1), .busy(busy1), .gidx(g1)
  );

  dbus_arbiter #(.NREQ(4), .RR(1'b0)) u2 (
    .clk(clk), .reset(reset), .ireq(req2), .iresp(ir2),
    .oreq(oq2), .oresp(rs2), .busy(busy2), .gidx(g2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state per instance: is a transaction held, by whom, and the scan start.
  bit mLock [3];
  int mLidx [3];
  int mPtr  [3];

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic dbus_req_t rndReq(input bit v);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = $urandom;
    r.size   = 3'($urandom);
    r.strobe = 4'($urandom);
    r.data   = $urandom;
    return r;
  endfunction

  function automatic dbus_resp_t rndResp(input bit ok);
    dbus_resp_t r;
    r.addr_ok = 1'($urandom);
    r.data_ok = ok;
    r.data    = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input int inst, input logic [3:0] vmask, input bit ok);
    case (inst)
      0: begin
        for (int i = 0; i < 2; i++) req0[i] = rndReq(vmask[i]);
        rs0 = rndResp(ok);
      end
      1: begin
        for (int i = 0; i < 4; i++) req1[i] = rndReq(vmask[i]);
        rs1 = rndResp(ok);
      end
      default: begin
        for (int i = 0; i < 4; i++) req2[i] = rndReq(vmask[i]);
        rs2 = rndResp(ok);
      end
    endcase
  endtask

  // Compare one instance with the model, then advance the model across the coming edge.
  task automatic checkOutput(input int inst);
    dbus_req_t  r  [4];
    dbus_resp_t ir [4];
    dbus_resp_t eIr [4];
    dbus_req_t  oq, eOq;
    dbus_resp_t rs;
    logic b;
    int g, n, w, sel, eG;
    bit rr, act, eB;
    n = 2; rr = 1'b1; oq = '0; rs = '0; b = 1'b0; g = 0;
    for (int i = 0; i < 4; i++) begin r[i] = '0; ir[i] = '0; end
    case (inst)
      0: begin
        n = 2; rr = 1'b1;
        for (int i = 0; i < 2; i++) begin r[i] = req0[i]; ir[i] = ir0[i]; end
        oq = oq0; rs = rs0; b = busy0; g = int'(g0);
      end
      1: begin
        n = 4; rr = 1'b1;
        for (int i = 0; i < 4; i++) begin r[i] = req1[i]; ir[i] = ir1[i]; end
        oq = oq1; rs = rs1; b = busy1; g = int'(g1);
      end
      default: begin
        n = 4; rr = 1'b0;
        for (int i = 0; i < 4; i++) begin r[i] = req2[i]; ir[i] = ir2[i]; end
        oq = oq2; rs = rs2; b = busy2; g = int'(g2);
      end
    endcase
    if (reset !== 1'b1) begin
      mLock[inst] = 1'b0; mLidx[inst] = 0; mPtr[inst] = 0;
    end
    w = -1;
    for (int k = 0; k < n; k++) begin
      if (w < 0 && r[(mPtr[inst] + k) % n].valid) w = (mPtr[inst] + k) % n;
    end
    eB = mLock[inst]; act = 1'b0; sel = 0; eG = 0;
    if (reset === 1'b1) begin
      if (mLock[inst]) begin
        sel = mLidx[inst]; eG = sel; act = r[sel].valid;
      end else if (w >= 0) begin
        sel = w; eG = w; act = 1'b1;
      end
    end
    eOq = act ? r[sel] : '0;
    for (int i = 0; i < 4; i++) eIr[i] = (act && i == sel) ? rs : '0;
    checkVal($sformatf("u%0d.busy", inst), 128'(b), 128'(eB));
    checkVal($sformatf("u%0d.gidx", inst), 128'(g), 128'(eG));
    checkVal($sformatf("u%0d.oreq", inst), 128'(oq), 128'(eOq));
    for (int i = 0; i < n; i++) begin
      checkVal($sformatf("u%0d.iresp%0d", inst, i), 128'(ir[i]), 128'(eIr[i]));
    end
    if (reset === 1'b1) begin
      if (mLock[inst]) begin
        if (!r[mLidx[inst]].valid) begin
          mLock[inst] = 1'b0;
        end else if (rs.data_ok) begin
          mLock[inst] = 1'b0;
          mPtr[inst]  = rr ? (mLidx[inst] + 1) % n : 0;
        end
      end else if (w >= 0) begin
        if (rs.data_ok) begin
          mPtr[inst] = rr ? (w + 1) % n : 0;
        end else begin
          mLock[inst] = 1'b1;
          mLidx[inst] = w;
        end
      end
    end
  endtask

  task automatic cycle();
    #3;
    for (int i = 0; i < 3; i++) checkOutput(i);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 4'b0000, 1'b0);
    #1;

    // Outputs stay quiet while reset is held, even with valid requests.
    applyStimulus(1, 4'b1111, 1'b0);
    applyStimulus(0, 4'b0011, 1'b0);
    cycle();
    cycle();
    checkVal("reset.oreq1", 128'(oq1), 128'(0));

    // Two-port round robin: port 0 locks, completes, then port 1 is next.
    applyStimulus(1, 4'b0000, 1'b0);
    reset = 1'b1;
    #1 checkVal("r2.first_gidx", 128'(g0), 128'(0));
    cycle();
    checkVal("r2.busy_c1", 128'(busy0), 128'(1));
    applyStimulus(0, 4'b0011, 1'b0);
    cycle();
    checkVal("r2.busy_c2", 128'(busy0), 128'(1));
    applyStimulus(0, 4'b0011, 1'b1);
    cycle();
    #1;
    checkVal("r2.busy_done", 128'(busy0), 128'(0));
    checkVal("r2.gidx_next", 128'(g0), 128'(1));
    checkVal("r2.oreq_next", 128'(oq0), 128'(req0[1]));
    cycle();
    applyStimulus(0, 4'b0000, 1'b0);

    // A lock on port 1 is not preempted by port 0 arriving.
    applyStimulus(1, 4'b0010, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 4'b0011, 1'b0);
      #1;
      checkVal("lock.oreq", 128'(oq1), 128'(req1[1]));
      checkVal("lock.gidx", 128'(g1), 128'(1));
      checkVal("lock.iresp0", 128'(ir1[0]), 128'(0));
      cycle();
    end
    applyStimulus(1, 4'b0011, 1'b1);
    cycle();
    applyStimulus(1, 4'b0101, 1'b1);
    #1 checkVal("lock.ptr2_wins", 128'(g1), 128'(2));
    cycle();

    // Single-cycle completions alternate between ports 3 and 0 with ptr wrapping.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 4'b1001, 1'b1);
      #1;
      checkVal("b2b.gidx", 128'(g1), (k % 2 == 0) ? 128'(3) : 128'(0));
      checkVal("b2b.busy", 128'(busy1), 128'(0));
      cycle();
    end
    applyStimulus(1, 4'b0000, 1'b0);

    // Fixed priority: port 0 always wins over port 2.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(2, 4'b0101, 1'($urandom_range(0, 1)));
      #1;
      checkVal("fixed.gidx", 128'(g2), 128'(0));
      checkVal("fixed.iresp2", 128'(ir2[2]), 128'(0));
      cycle();
    end
    applyStimulus(2, 4'b0000, 1'b0);
    cycle();

    // Requester flush during LOCK aborts without moving ptr.
    applyStimulus(1, 4'b0010, 1'b0);
    cycle();
    applyStimulus(1, 4'b0010, 1'b0);
    cycle();
    checkVal("flush.busy_before", 128'(busy1), 128'(1));
    applyStimulus(1, 4'b0000, 1'b0);
    #1;
    checkVal("flush.oreq", 128'(oq1), 128'(0));
    checkVal("flush.iresp1", 128'(ir1[1]), 128'(0));
    cycle();
    checkVal("flush.busy_after", 128'(busy1), 128'(0));
    applyStimulus(1, 4'b0000, 1'b0);
    #1 checkVal("flush.iresp1_later", 128'(ir1[1]), 128'(0));
    cycle();
    applyStimulus(1, 4'b1010, 1'b1);
    #1 checkVal("flush.ptr_kept", 128'(g1), 128'(1));
    cycle();

    // Reset in the middle of a lock clears it at once; restart scans from port 0.
    applyStimulus(1, 4'b0100, 1'b0);
    cycle();
    checkVal("rst.busy_locked", 128'(busy1), 128'(1));
    applyStimulus(1, 4'b0110, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkVal("rst.busy_async", 128'(busy1), 128'(0));
    checkVal("rst.oreq_async", 128'(oq1), 128'(0));
    cycle();
    cycle();
    reset = 1'b1;
    applyStimulus(1, 4'b0110, 1'b0);
    #1 checkVal("rst.first_grant", 128'(g1), 128'(1));
    cycle();

    // Randomized traffic on all instances with occasional reset pulses.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(i, 4'($urandom), $urandom_range(0, 9) < 4);
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requester ports (2..8).
REQ-002 The block SHALL have parameter RR, default 1: 1 selects round-robin priority, 0 selects fixed priority (port 0 highest).
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-low (reset==0 resets).
REQ-005 The block SHALL have port ireq, input, dbus_req_t[NREQ]: the requests from each requester.
REQ-006 The block SHALL have port iresp, output, dbus_resp_t[NREQ]: the responses to each requester.
REQ-007 The block SHALL have port oreq, output, dbus_req_t: the request to the data bus.
REQ-008 The block SHALL have port oresp, input, dbus_resp_t: the response from the data bus.
REQ-009 The block SHALL have port busy, output, 1 bit: a locked transaction is in flight.
REQ-010 The block SHALL have port gidx, output, $clog2(NREQ) bits: the index of the current or locked grant.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and LOCK.
REQ-012 In IDLE with no ireq[i].valid, oreq SHALL be all-zero, every iresp SHALL be all-zero, and the state SHALL remain IDLE.
REQ-013 In IDLE with any valid request, the winner w SHALL be the first valid port at or after ptr, scanning upward and wrapping modulo NREQ; with RR=0, ptr is fixed at 0.
REQ-014 The winner SHALL be forwarded combinationally in the same cycle: oreq=ireq[w], iresp[w]=oresp, all other iresp all-zero, and gidx=w; the arbiter adds zero latency.
REQ-015 IDLE→LOCK SHALL occur when a winner exists and oresp.data_ok==0; the locked index lidx SHALL be set to w.
REQ-016 If oresp.data_ok==1 in the same IDLE cycle as the grant, the transaction SHALL complete, the state SHALL remain IDLE, and ptr SHALL update.
REQ-017 In LOCK, oreq SHALL be ireq[lidx] and iresp[lidx] SHALL be oresp, independent of all other ports' valid; a higher-priority arrival SHALL NOT preempt the lock.
REQ-018 LOCK→IDLE SHALL occur on oresp.data_ok==1, which counts as completion.
REQ-019 LOCK→IDLE SHALL also occur if ireq[lidx].valid==0 (requester flush), with oreq all-zero that cycle; ptr SHALL NOT update on this abort.
REQ-020 On completion with RR=1, ptr SHALL become (granted index+1) mod NREQ; the wrap from NREQ-1 to 0 is required.
REQ-021 busy SHALL be 1 exactly when the state is LOCK.
REQ-022 gidx SHALL equal w in IDLE, lidx in LOCK, and 0 when idle with no request.
REQ-023 Non-granted requesters SHALL see addr_ok=0 and data_ok=0 on every cycle.

Reset
REQ-024 While reset==0, asynchronously: state=IDLE, ptr=0, lidx=0.
REQ-025 During reset, outputs SHALL follow REQ-012 (busy=0, gidx=0).
REQ-026 Reset asserted mid-LOCK SHALL abandon the transaction with no completion or ptr update; after release, arbitration SHALL restart from port 0.

Structure
REQ-027 The state enum (IDLE, LOCK) SHALL live in package pipes; dbus_req_t and dbus_resp_t SHALL remain in package common.
REQ-028 Winner selection SHALL be one sub-module, rr_pick (inputs: valid vector and ptr; outputs: found and index), and SHALL be purely combinational.
REQ-029 In core, dbus_arbiter SHALL instantiate with NREQ=2, port 0=fetch page-walk, and port 1=memory.

Verification
REQ-030 Bench: NREQ=2, RR=1, both valid at reset release, data_ok on cycle 3 → port 0 granted, busy=1 cycles 1-2, port 1 granted cycle 4, gidx=1.
REQ-031 Bench: LOCK on port 1 with NREQ=4; port 0 asserts valid mid-transaction → oreq stays ireq[1] until data_ok, then ptr=2 and port 2 would precede port 0.
REQ-032 Bench: single-cycle data_ok in IDLE, port 3 of 4, 5 back-to-back requests → busy never 1, ptr wraps 0, and grants alternate correctly.
REQ-033 Bench: RR=0, ports 0 and 2 continuously valid → port 0 granted every transaction and port 2 never granted.
REQ-034 Bench: port 1 drops valid during LOCK → next cycle IDLE, ptr unchanged, and iresp[1] zero thereafter.
REQ-035 Bench: reset=0 asserted mid-LOCK → busy=0 immediately (asynchronous), oreq zero, and first grant after release is the lowest valid port.
